// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: merges stall requests,
// converts MEM exceptions/ERET into flush + redirect, tracks stall statistics.
module pipeline_ctrl #(
   parameter logic [31:0] EBASE       = 32'h00000020,
   parameter int          FLUSH_HOLD  = 1,
   parameter int          WDOG_CYCLES = 1024,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic [31:0]      excepttype_i,
   input  logic [31:0]      cp0_epc_i,
   output logic [5:0]       stall_o,
   output logic             flush_o,
   output logic [31:0]      new_pc_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [15:0]      flush_count_o,
   output logic             stall_timeout_o,
   output logic             hold_o
);

   localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(FLUSH_HOLD - 1);
   localparam logic [WW-1:0] WD_MAX    = WW'(WDOG_CYCLES);
   localparam logic [31:0]   ERET_CODE = 32'h0000000e;

   typedef enum logic {
      S_RUN,
      S_HOLD
   } state_t;

   state_t            r_state;
   logic [HW-1:0]     r_hold_cnt;
   logic [WW-1:0]     r_wdog;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [15:0]       r_flush_cnt;
   logic              r_timeout;
   logic              w_accept;
   logic              w_stalled;

   assign w_accept = !rst && (r_state == S_RUN) && (excepttype_i != 32'd0);

   // Flush overrides any stall request in the same cycle.
   always_comb begin
      stall_o  = 6'b000000;
      flush_o  = 1'b0;
      new_pc_o = 32'd0;
      if (rst) begin
         stall_o = 6'b000000;
      end else if (w_accept) begin
         flush_o  = 1'b1;
         new_pc_o = (excepttype_i == ERET_CODE) ? cp0_epc_i : EBASE;
      end else if (stallreq_mem) begin
         stall_o = 6'b011111;
      end else if (stallreq_ex) begin
         stall_o = 6'b001111;
      end else if (stallreq_id) begin
         stall_o = 6'b000111;
      end else if (stallreq_if) begin
         stall_o = 6'b000011;
      end
   end

   assign w_stalled = (stall_o != 6'b000000);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_hold_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_wdog      <= '0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_accept) begin
                  r_state    <= S_HOLD;
                  r_hold_cnt <= HOLD_LOAD;
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == '0) begin
                  r_state <= S_RUN;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            default: r_state <= S_RUN;
         endcase

         if (stall_o[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_accept && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end

         // Watchdog parks at its limit while the stall persists.
         if (!w_stalled || flush_o) begin
            r_wdog <= '0;
         end else if (r_wdog != WD_MAX) begin
            r_wdog <= r_wdog + 1'b1;
            if (r_wdog == WD_MAX - 1'b1) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   assign stall_cycles_o  = r_stall_cnt;
   assign flush_count_o   = r_flush_cnt;
   assign stall_timeout_o = r_timeout;
   assign hold_o          = (r_state == S_HOLD);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;

   localparam int FH   = 1;
   localparam int WD   = 8;
   localparam int CW   = 4;
   localparam logic [31:0] EB = 32'h00000020;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_if, s_id, s_ex, s_mem;
   logic [31:0]   exc, epc;
   logic [5:0]    stall;
   logic          flush;
   logic [31:0]   npc;
   logic [CW-1:0] scyc;
   logic [15:0]   fcnt;
   logic          tmo;
   logic          hold;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_hold_left = 0;
   int m_sc        = 0;
   int m_fc        = 0;
   int m_run       = 0;
   bit m_to        = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .EBASE(EB), .FLUSH_HOLD(FH), .WDOG_CYCLES(WD), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .stallreq_if(s_if), .stallreq_id(s_id),
      .stallreq_ex(s_ex), .stallreq_mem(s_mem),
      .excepttype_i(exc), .cp0_epc_i(epc),
      .stall_o(stall), .flush_o(flush), .new_pc_o(npc),
      .stall_cycles_o(scyc), .flush_count_o(fcnt),
      .stall_timeout_o(tmo), .hold_o(hold)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // req: bit0 if, bit1 id, bit2 ex, bit3 mem
   task automatic step(input logic r, input logic [3:0] req,
                       input logic [31:0] e, input logic [31:0] pc);
      int lvl;
      bit acc;
      logic [5:0]  x_st;
      logic        x_fl;
      logic [31:0] x_pc;
      rst = r; s_if = req[0]; s_id = req[1]; s_ex = req[2]; s_mem = req[3];
      exc = e; epc = pc;
      #1;
      acc  = !r && (m_hold_left == 0) && (e != 0);
      lvl  = req[3] ? 4 : req[2] ? 3 : req[1] ? 2 : req[0] ? 1 : 0;
      x_st = (r || acc || lvl == 0) ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
      x_fl = acc;
      x_pc = !acc ? 32'd0 : (e == 32'he) ? pc : EB;
      chk("stall_o", 32'(stall), 32'(x_st));
      chk("flush_o", 32'(flush), 32'(x_fl));
      chk("new_pc_o", npc, x_pc);
      chk("stall_cycles_o", 32'(scyc), m_sc);
      chk("flush_count_o", 32'(fcnt), m_fc);
      chk("stall_timeout_o", 32'(tmo), 32'(m_to));
      chk("hold_o", 32'(hold), 32'(m_hold_left != 0));
      @(posedge clk);
      if (r) begin
         m_hold_left = 0; m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
      end else begin
         if (acc) begin
            m_hold_left = FH;
            if (m_fc < 65535) m_fc++;
         end else if (m_hold_left > 0) begin
            m_hold_left--;
         end
         if (x_st[0] && m_sc < (1 << CW) - 1) m_sc++;
         if (x_st == 0) m_run = 0;
         else if (m_run < WD) m_run++;
         if (m_run >= WD) m_to = 1;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] e;
      rst = 1'b1; s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
      exc = 0; epc = 0;
      @(posedge clk);
      @(negedge clk);
      step(1, 4'b0000, 0, 0);
      step(0, 4'b0000, 0, 0);
      // stall priority, id+ex for 3 cycles
      repeat (3) step(0, 4'b0110, 0, 0);
      step(0, 4'b0000, 0, 0);
      // exception together with mem stall
      step(0, 4'b1000, 32'h8, 32'h1234);
      step(0, 4'b0000, 0, 0);
      step(0, 4'b0000, 0, 0);
      // ERET
      step(0, 4'b0000, 32'he, 32'hBFC00100);
      step(0, 4'b0000, 0, 0);
      step(0, 4'b0000, 0, 0);
      // back-to-back exceptions, third two cycles after first
      step(0, 4'b0000, 32'h4, 0);
      step(0, 4'b0001, 32'h4, 0);
      step(0, 4'b0000, 32'h4, 0);
      step(0, 4'b0000, 0, 0);
      step(0, 4'b0000, 0, 0);
      // watchdog
      step(1, 4'b0000, 0, 0);
      repeat (8) step(0, 4'b0001, 0, 0);
      step(0, 4'b0001, 0, 0);
      step(0, 4'b0000, 0, 0);
      step(1, 4'b0000, 0, 0);
      step(0, 4'b0000, 0, 0);
      // counter saturation, then reset inside HOLD
      repeat (20) step(0, 4'b0100, 0, 0);
      step(0, 4'b0100, 32'h10, 0);
      step(1, 4'b0100, 0, 0);
      step(0, 4'b0000, 32'h10, 0);
      step(0, 4'b0000, 0, 0);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0)
            e = $urandom_range(0, 1) ? 32'he : ($urandom | 32'd1);
         else
            e = 32'd0;
         step($urandom_range(0, 59) == 0, 4'($urandom), e, $urandom);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
